uart_tx_front: RTL and testbench
================================

UART_TX_FRONT -- requirements
Module: uart_tx_front

Parameters
REQ-001 CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range is 2 or more (16 gives 160 ns/bit at a 10 ns clk).
REQ-002 STOP_BITS, default 1, number of stop bits per frame; legal values are 1 and 2.

Interface
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_tx  input  8  byte to transmit, sampled only on acceptance.
REQ-006 uart_valid  input  1  source has a byte on data_tx.
REQ-007 uart_ready  output  1  block can accept a byte this cycle.
REQ-008 uart_tx  output  1  serial line, idle high, registered.
REQ-009 tx_busy  output  1  a frame is in progress (START, DATA or STOP state).

Function
REQ-010 The block SHALL accept a byte on a rising edge where uart_valid=1 and uart_ready=1; uart_valid with uart_ready=0 SHALL have no effect.
REQ-011 The block SHALL capture data_tx into an internal shift register on acceptance; later changes to data_tx SHALL NOT affect the frame in flight.
REQ-012 The state machine SHALL have states IDLE, START, DATA and STOP: IDLE->START on acceptance; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bits; STOP->IDLE after STOP_BITS*CLKS_PER_BIT cycles, or STOP->START on acceptance in the final stop cycle.
REQ-013 uart_tx SHALL go low in the first cycle after the acceptance edge, with 0 cycles of extra latency.
REQ-014 Each start, data and stop bit SHALL be held on uart_tx for exactly CLKS_PER_BIT cycles.
REQ-015 Data bits SHALL be sent LSB first, bit 0 through bit 7.
REQ-016 No parity bit SHALL be sent; stop bits SHALL be 1.
REQ-017 Total frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-018 uart_ready SHALL be 1 in IDLE and in the final cycle of the last stop bit, and 0 in all other cycles.
REQ-019 Acceptance in the final stop cycle SHALL start the next start bit in the very next cycle, giving back-to-back frames with no idle gap.
REQ-020 tx_busy SHALL be 1 whenever the state is not IDLE, including the final stop cycle.
REQ-021 In IDLE, uart_tx SHALL be held at 1.
REQ-022 The bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at CLKS_PER_BIT-1.
REQ-023 The bit index counter SHALL be 3 bits wide; DATA SHALL end when index 7 completes its period.
REQ-024 A source that asserts uart_valid while not ready SHALL keep uart_valid and data_tx stable until accepted; the block does not buffer more than one byte.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set state=IDLE, uart_tx=1, tx_busy=0, and both counters to 0.
REQ-026 uart_ready SHALL read 1 in the cycle after reset deasserts; uart_valid sampled while rst=1 SHALL be ignored.
REQ-027 Reset mid-frame SHALL abort the frame with uart_tx=1 from the next cycle; the aborted byte SHALL NOT be resumed or retransmitted.

Verification
REQ-028 Single byte: accept 0x55 with CLKS_PER_BIT=16 -> uart_tx is 0 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then 1 for 16 cycles; uart_ready is low for 159 cycles; frame is 160 cycles.
REQ-029 Back-to-back: hold uart_valid with 0x0F then 0xA5 -> the second start bit begins the cycle after the first frame's last stop cycle; uart_ready pulses high for exactly 1 cycle between frames; 320 cycles total.
REQ-030 Data stability: accept 0x94, then change data_tx to 0xFF during bit 2 -> the serialized bits are still 0,0,1,0,1,0,0,1.
REQ-031 Reset abort: assert rst for 1 cycle during data bit 3 of 0x31 -> the next cycle shows uart_tx=1, tx_busy=0, uart_ready=1, and no further low bits appear.
REQ-032 Loopback: connect uart_tx to the uart_front receiver's uart_rx and send 0x55, 0x0F, 0x94, 0x31 -> the receiver's data_rx matches each byte in order.
REQ-033 STOP_BITS=2: accept 0xA5 -> frame is 176 cycles, stop high for 32 cycles, and uart_ready asserts only in cycle 176.

Source files
------------

// File: rtl/uart_tx_front.sv
// uart_tx_front: 8N1/8N2 UART transmitter front end with a valid/ready byte
// interface. One byte is captured per frame. A new byte offered in the last
// stop cycle chains straight into the next start bit, so there is no idle gap.
module uart_tx_front #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_tx,
    input  logic       uart_valid,
    output logic       uart_ready,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam int              CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;     // cycles elapsed within the current bit
    logic [2:0]    idx;     // data bit index, reused as stop bit index
    logic [7:0]    shreg;   // captured byte, shifted right as bits go out

    logic bit_end;
    logic stop_end;
    logic accept;

    // Bit boundary, final stop cycle and handshake decode from registered state
    always_comb begin
        bit_end    = (cnt == CNT_LAST);
        stop_end   = (state == STOP) && bit_end && (idx == STOP_LAST);
        uart_ready = (state == IDLE) || stop_end;
        accept     = uart_valid && uart_ready;
    end

    // Frame sequencer: state, counters, shift register and registered line/busy
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (accept) begin
                        state   <= START;
                        shreg   <= data_tx;
                        uart_tx <= 1'b0;
                        tx_busy <= 1'b1;
                        cnt     <= '0;
                        idx     <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        cnt     <= '0;
                        idx     <= '0;
                        uart_tx <= shreg[0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
                            state   <= STOP;
                            idx     <= '0;
                            uart_tx <= 1'b1;
                        end else begin
                            idx     <= idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == STOP_LAST) begin
                            idx <= '0;
                            if (uart_valid) begin
                                // chain the next frame with no idle cycle
                                state   <= START;
                                shreg   <= data_tx;
                                uart_tx <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                                uart_tx <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_front.sv
// Bench for uart_tx_front: three instances with different bit periods and
// stop-bit counts, each checked every cycle against a frame-position model.
module tb_uart_tx_front;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       data [N];
    logic [N-1:0]     valid;
    logic [N-1:0]     ready;
    logic [N-1:0]     tx;
    logic [N-1:0]     busy;

    always #5 clk = ~clk;

    uart_tx_front #(.CLKS_PER_BIT(16), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .data_tx(data[0]), .uart_valid(valid[0]),
        .uart_ready(ready[0]), .uart_tx(tx[0]), .tx_busy(busy[0]));
    uart_tx_front #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .data_tx(data[1]), .uart_valid(valid[1]),
        .uart_ready(ready[1]), .uart_tx(tx[1]), .tx_busy(busy[1]));
    uart_tx_front #(.CLKS_PER_BIT(3), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .data_tx(data[2]), .uart_valid(valid[2]),
        .uart_ready(ready[2]), .uart_tx(tx[2]), .tx_busy(busy[2]));

    int total = 0;
    int bad   = 0;

    function automatic int cpb(int i);
        return (i == 2) ? 3 : 16;
    endfunction
    function automatic int sbits(int i);
        return (i == 1) ? 2 : 1;
    endfunction
    function automatic int flen(int i);
        return (9 + sbits(i)) * cpb(i);
    endfunction

    // Model: position within the current frame (-1 when idle) and its byte
    int          pos   [N];
    logic [7:0]  mbyte [N];
    logic [N-1:0] acc;

    function automatic logic exp_tx(int i);
        int b;
        if (pos[i] < 0) return 1'b1;
        b = pos[i] / cpb(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return mbyte[i][b-1];
        return 1'b1;
    endfunction
    function automatic logic exp_ready(int i);
        return (pos[i] < 0) || (pos[i] == flen(i) - 1);
    endfunction
    function automatic logic exp_busy(int i);
        return pos[i] >= 0;
    endfunction

    // Per-instance byte sources (ring buffers)
    logic [7:0] sbuf [N][64];
    int         shead [N];
    int         stail [N];
    bit         rnd_mode = 1'b0;

    // Directed-phase statistics
    int   busy_cnt [N];
    int   rdy_lo   [N];
    int   rdy_busy [N];
    int   low_cnt  [N];
    logic txlog [0:1023];
    int   logn;

    task automatic check(string nm, int i, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, i, act, want, $time);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            busy_cnt[i] = 0; rdy_lo[i] = 0; rdy_busy[i] = 0; low_cnt[i] = 0;
        end
        logn = 0;
    endtask

    task automatic push(int i, logic [7:0] b);
        sbuf[i][stail[i] % 64] = b;
        stail[i]++;
    endtask

    // One clock: advance model at the edge, compare after it, drive at negedge
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            acc[i] = 1'b0;
            if (rst) begin
                pos[i] = -1;
            end else if (exp_ready(i) && valid[i]) begin
                pos[i]   = 0;
                mbyte[i] = data[i];
                acc[i]   = 1'b1;
            end else if (pos[i] >= 0) begin
                pos[i]++;
                if (pos[i] == flen(i)) pos[i] = -1;
            end
        end
        #1;
        for (int i = 0; i < N; i++) begin
            check("uart_tx",    i, int'(tx[i]),    int'(exp_tx(i)));
            check("uart_ready", i, int'(ready[i]), int'(exp_ready(i)));
            check("tx_busy",    i, int'(busy[i]),  int'(exp_busy(i)));
            if (busy[i])             busy_cnt[i]++;
            if (!ready[i])           rdy_lo[i]++;
            if (ready[i] && busy[i]) rdy_busy[i]++;
            if (!tx[i])              low_cnt[i]++;
        end
        if (logn < 1024) begin
            txlog[logn] = tx[0];
            logn++;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (valid[i] && !acc[i]) continue;   // hold until accepted
            if (acc[i]) shead[i]++;
            if (shead[i] != stail[i] && (!rnd_mode || $urandom_range(2) != 0)) begin
                valid[i] = 1'b1;
                data[i]  = sbuf[i][shead[i] % 64];
            end else begin
                valid[i] = 1'b0;
                data[i]  = rnd_mode ? 8'($urandom) : 8'hFF;
            end
        end
    endtask

    // Decode the first frame in DUT0's log, sampling mid-bit
    function automatic logic [7:0] decode0(output logic stop_ok);
        int k;
        logic [7:0] v;
        k = -1;
        for (int j = 0; j < logn; j++)
            if (k < 0 && txlog[j] == 1'b0) k = j;
        v = 8'h00;
        stop_ok = 1'b0;
        if (k >= 0 && k + 16 * 9 + 8 < logn) begin
            for (int b = 0; b < 8; b++) v[b] = txlog[k + 16 * (b + 1) + 8];
            stop_ok = txlog[k + 16 * 9 + 8];
        end
        return v;
    endfunction

    logic       stop_ok;
    logic [7:0] got;
    int         waited;

    initial begin
        for (int i = 0; i < N; i++) begin
            pos[i] = -1; mbyte[i] = 8'h00; shead[i] = 0; stail[i] = 0;
            data[i] = 8'h3C;
        end
        acc   = '0;
        rst   = 1'b1;
        valid = '1;            // offered during reset: must be ignored
        clear_stats();
        @(negedge clk);
        repeat (3) step();
        rst   = 1'b0;
        valid = '0;
        step();
        check("reset_ready", 0, int'(ready[0]), 1);
        check("reset_tx",    0, int'(tx[0]),    1);
        check("reset_busy",  0, int'(busy[0]),  0);

        // Single byte 0x55 on every instance
        clear_stats();
        for (int i = 0; i < N; i++) push(i, 8'h55);
        repeat (200) step();
        got = decode0(stop_ok);
        check("byte_55",      0, int'(got), 8'h55);
        check("stop_55",      0, int'(stop_ok), 1);
        check("frame_len",    0, busy_cnt[0], 160);
        check("ready_low",    0, rdy_lo[0], 159);
        check("low_cycles",   0, low_cnt[0], 80);
        check("frame_len",    1, busy_cnt[1], 176);
        check("ready_low",    1, rdy_lo[1], 175);
        check("frame_len",    2, busy_cnt[2], 30);
        check("ready_low",    2, rdy_lo[2], 29);

        // 0x94 with data_tx forced to 0xFF once accepted
        clear_stats();
        push(0, 8'h94);
        repeat (180) step();
        got = decode0(stop_ok);
        check("byte_94", 0, int'(got), 8'h94);

        // Back-to-back 0x0F then 0xA5 with valid held
        clear_stats();
        for (int i = 0; i < N; i++) begin
            push(i, 8'h0F);
            push(i, 8'hA5);
        end
        repeat (400) step();
        check("b2b_len",     0, busy_cnt[0], 320);
        check("b2b_rdybusy", 0, rdy_busy[0], 2);
        check("b2b_low",     0, low_cnt[0], 160);
        check("b2b_len",     1, busy_cnt[1], 352);

        // Reset abort during data bit 3 of 0x31
        push(0, 8'h31);
        waited = 0;
        while (pos[0] != 16 * 4 + 5 && waited < 500) begin
            step();
            waited++;
        end
        if (waited >= 500) begin
            bad++;
            total++;
            $display("FAIL abort_wait dut0: got timeout expected data bit 3");
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_tx",    0, int'(tx[0]),    1);
        check("abort_busy",  0, int'(busy[0]),  0);
        check("abort_ready", 0, int'(ready[0]), 1);
        clear_stats();
        repeat (100) step();
        check("abort_quiet", 0, low_cnt[0], 0);

        // Randomized traffic with occasional reset
        rnd_mode = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < N; i++)
                if (stail[i] - shead[i] < 3 && $urandom_range(20) == 0)
                    push(i, 8'($urandom));
            rst = ($urandom_range(900) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
